// File: rtl/bin_window_3x3.sv
`default_nettype none
// bin_window_3x3 : 3x3 sliding window over a 1-bit pixel stream, two line memories, 2-cycle latency.
// Rev 1.0
module bin_window_3x3 #(
  parameter int IMG_WIDTH_LINE = 1024,
  parameter int ADDR_W         = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix_vs,
  input  logic              pix_de,
  input  logic              pix_bit,
  output logic [8:0]        win,
  output logic              win_de,
  output logic              win_vs,
  output logic [ADDR_W-1:0] win_col,
  output logic [ADDR_W-1:0] win_row
);

  localparam int                MEM_AW    = (IMG_WIDTH_LINE > 1) ? $clog2(IMG_WIDTH_LINE) : 1;
  localparam logic [ADDR_W-1:0] COL_LIMIT = ADDR_W'(IMG_WIDTH_LINE);
  localparam logic [ADDR_W-1:0] ROW_MAX   = '1;
  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] TWO       = ADDR_W'(2);

  logic              vs_prev, de_prev, fall_d, armed, vs_p1, vs_p2;
  logic [ADDR_W-1:0] col, row;
  logic              s1_de, s1_bit;
  logic [ADDR_W-1:0] s1_col, s1_row;
  logic [2:0]        sr_old, sr_mid, sr_new;
  logic              l1_q, l2_q;
  logic              mem_l1 [IMG_WIDTH_LINE];
  logic              mem_l2 [IMG_WIDTH_LINE];

  logic              vs_rise, de_fall, accept, win_ok;
  logic [ADDR_W-1:0] cur_col, cur_row;
  logic [MEM_AW-1:0] rd_addr, wr_addr;

  // A frame start overrides the counters for the pixel arriving in the same cycle.
  always_comb begin
    vs_rise = pix_vs & ~vs_prev;
    de_fall = de_prev & ~pix_de;
    cur_col = vs_rise ? '0 : col;
    cur_row = vs_rise ? '0 : row;
    accept  = pix_de & (cur_col < COL_LIMIT) & (armed | vs_rise);
    win_ok  = s1_de & (s1_col >= TWO) & (s1_row >= TWO);
    rd_addr = cur_col[MEM_AW-1:0];
    wr_addr = s1_col[MEM_AW-1:0];
  end

  assign win    = {sr_old, sr_mid, sr_new};
  assign win_vs = vs_p2;

  // vs_prev resets high so only a genuine low-to-high frame sync re-arms the block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_prev <= 1'b1;
      de_prev <= 1'b0;
      fall_d  <= 1'b0;
      armed   <= 1'b0;
      vs_p1   <= 1'b0;
      vs_p2   <= 1'b0;
      col     <= '0;
      row     <= '0;
    end else begin
      vs_prev <= pix_vs;
      de_prev <= pix_de;
      fall_d  <= de_fall;
      vs_p1   <= pix_vs;
      vs_p2   <= vs_p1;
      if (vs_rise) begin
        armed <= 1'b1;
      end
      if (pix_de) begin
        col <= (cur_col < COL_LIMIT) ? cur_col + ONE : cur_col;
      end else begin
        col <= '0;
      end
      if (vs_rise) begin
        row <= '0;
      end else if (de_fall && row != ROW_MAX) begin
        row <= row + ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_de   <= 1'b0;
      s1_bit  <= 1'b0;
      s1_col  <= '0;
      s1_row  <= '0;
      sr_old  <= '0;
      sr_mid  <= '0;
      sr_new  <= '0;
      win_de  <= 1'b0;
      win_col <= '0;
      win_row <= '0;
    end else begin
      s1_de  <= accept;
      s1_bit <= pix_bit;
      s1_col <= cur_col;
      s1_row <= cur_row;
      if (vs_rise) begin
        sr_old <= '0;
        sr_mid <= '0;
        sr_new <= '0;
        win_de <= 1'b0;
      end else begin
        win_de <= win_ok;
        if (win_ok) begin
          win_col <= s1_col - ONE;
          win_row <= s1_row - ONE;
        end
        // Clearing waits one cycle after the falling edge so the last pixel still shifts in.
        if (s1_de) begin
          sr_old <= {sr_old[1:0], l2_q};
          sr_mid <= {sr_mid[1:0], l1_q};
          sr_new <= {sr_new[1:0], s1_bit};
        end else if (fall_d) begin
          sr_old <= '0;
          sr_mid <= '0;
          sr_new <= '0;
        end
      end
    end
  end

  // Write trails read by one cycle, so each address is read before it is overwritten.
  always_ff @(posedge clk) begin
    l1_q <= mem_l1[rd_addr];
    l2_q <= mem_l2[rd_addr];
    if (s1_de) begin
      mem_l1[wr_addr] <= s1_bit;
      mem_l2[wr_addr] <= l1_q;
    end
  end

endmodule
`default_nettype wire
